// File: rtl/ysyx_22040175_ifu.sv
// Instruction fetch unit: single-outstanding fetcher feeding a 2-entry {pc,inst} queue.
// Redirects flush the queue and retarget the fetch pc; an in-flight response is dropped.
module ysyx_22040175_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        req_hs, push, pop;
  logic [31:0] rsp_word;

  assign mem_req_valid = (state_q == IDLE) && (count_q < 2'd2);
  assign mem_req_addr  = pc_q;
  assign req_hs        = mem_req_valid && mem_req_ready;

  // The requested word sits in the upper half of the doubleword when pc[2] is set.
  assign rsp_word = req_pc_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];

  assign push = (state_q == WAIT) && mem_rsp_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[31:2], 2'b00};
    else if (req_hs)
      pc_d = pc_q + 32'd4;
  end

  always_comb begin
    count_d = count_q;
    if (redirect_valid)
      count_d = 2'd0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      if (req_hs)
        req_pc_q <= pc_q;
      if (redirect_valid) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
      case (state_q)
        // A request accepted alongside a redirect is stale: its response must be dropped.
        IDLE: if (req_hs) state_q <= redirect_valid ? DROP : WAIT;
        WAIT: begin
          if (redirect_valid)
            state_q <= mem_rsp_valid ? IDLE : DROP;
          else if (mem_rsp_valid)
            state_q <= IDLE;
        end
        DROP:    if (mem_rsp_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_inst_q[wr_ptr_q] <= rsp_word;
    end
  end

endmodule
